// File: rtl/pcie_rx_tag_sched_if.sv
// Bundle of request, TX MRd issue and CplD tag-report signals shared by the
// tag scheduler (slave) and its surrounding environment (master).
interface pcie_rx_tag_sched_if #(
  parameter int C_TAG_WIDTH       = 3,
  parameter int C_PCIE_ADDR_WIDTH = 36
);
  logic                         req0_valid;
  logic [C_PCIE_ADDR_WIDTH-1:0] req0_addr;
  logic [9:0]                   req0_len;
  logic                         req0_ready;
  logic                         req1_valid;
  logic [C_PCIE_ADDR_WIDTH-1:0] req1_addr;
  logic [9:0]                   req1_len;
  logic                         req1_ready;
  logic                         tx_mrd_req;
  logic [C_PCIE_ADDR_WIDTH-3:0] tx_mrd_addr;
  logic [9:0]                   tx_mrd_len;
  logic [7:0]                   tx_mrd_tag;
  logic                         tx_mrd_ack;
  logic [7:0]                   cpld_fifo_tag;
  logic                         cpld_fifo_wr_en;
  logic                         cpld_fifo_tag_last;
  logic                         cpld_owner;
  logic [C_TAG_WIDTH:0]         tag_outstanding;
  logic                         pcie_cpld_tag_err;

  modport master (
    output req0_valid, req0_addr, req0_len, req1_valid, req1_addr, req1_len,
    output tx_mrd_ack, cpld_fifo_tag, cpld_fifo_wr_en, cpld_fifo_tag_last,
    input  req0_ready, req1_ready, tx_mrd_req, tx_mrd_addr, tx_mrd_len, tx_mrd_tag,
    input  cpld_owner, tag_outstanding, pcie_cpld_tag_err
  );

  modport slave (
    input  req0_valid, req0_addr, req0_len, req1_valid, req1_addr, req1_len,
    input  tx_mrd_ack, cpld_fifo_tag, cpld_fifo_wr_en, cpld_fifo_tag_last,
    output req0_ready, req1_ready, tx_mrd_req, tx_mrd_addr, tx_mrd_len, tx_mrd_tag,
    output cpld_owner, tag_outstanding, pcie_cpld_tag_err
  );
endinterface

// File: rtl/pcie_rx_tag_sched.sv
// Tag allocator and round-robin arbiter for two DMA read requesters sharing one
// TX MRd port; tags are recycled when the last CplD write for them is reported.
module pcie_rx_tag_sched #(
  parameter int C_TAG_WIDTH       = 3,
  parameter int C_PCIE_ADDR_WIDTH = 36
) (
  input logic               pcie_user_clk,
  input logic               pcie_user_rst,
  pcie_rx_tag_sched_if.slave bus
);
  localparam int NTAGS = 1 << C_TAG_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;

  state_t                       state_q, state_d;
  logic [NTAGS-1:0]             busy_q, busy_d;
  logic [NTAGS-1:0]             owner_q, owner_d;
  logic                         rr_ptr_q;
  logic                         grant_q, grant_d;
  logic [C_PCIE_ADDR_WIDTH-3:0] addr_q;
  logic [9:0]                   len_q;
  logic [C_TAG_WIDTH-1:0]       tag_q;
  logic [C_TAG_WIDTH:0]         outstanding_q, outstanding_d;
  logic                         tag_err_q;
  logic                         alloc;
  logic [C_TAG_WIDTH-1:0]       free_idx;
  logic                         any_free;
  logic [C_TAG_WIDTH-1:0]       cpl_idx;
  logic                         cpl_in_pool;
  logic                         cpl_release;
  logic                         cpl_stray;
  logic                         unused_addr_bits;

  // Byte-offset bits never reach the DW-addressed TX request.
  assign unused_addr_bits = ^{bus.req0_addr[1:0], bus.req1_addr[1:0]};

  // Lowest-index free tag wins, so scan from the top down.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = NTAGS - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_idx = C_TAG_WIDTH'(i);
        any_free = 1'b1;
      end
    end
  end

  assign grant_d     = (bus.req0_valid && bus.req1_valid) ? rr_ptr_q : bus.req1_valid;
  assign cpl_idx     = bus.cpld_fifo_tag[C_TAG_WIDTH-1:0];
  assign cpl_in_pool = (bus.cpld_fifo_tag >> C_TAG_WIDTH) == 8'd0;
  assign cpl_stray   = bus.cpld_fifo_wr_en && (!cpl_in_pool || !busy_q[cpl_idx]);
  assign cpl_release = bus.cpld_fifo_wr_en && bus.cpld_fifo_tag_last &&
                       cpl_in_pool && busy_q[cpl_idx];

  always_comb begin
    state_d = state_q;
    alloc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((bus.req0_valid || bus.req1_valid) && any_free) begin
          alloc   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ:   if (bus.tx_mrd_ack) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Allocation and release never hit the same tag, so applying both is safe.
  always_comb begin
    busy_d        = busy_q;
    owner_d       = owner_q;
    outstanding_d = '0;
    if (alloc) begin
      busy_d[free_idx]  = 1'b1;
      owner_d[free_idx] = grant_d;
    end
    if (cpl_release) busy_d[cpl_idx] = 1'b0;
    for (int i = 0; i < NTAGS; i++) begin
      outstanding_d = outstanding_d + {{C_TAG_WIDTH{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge pcie_user_clk) begin
    if (pcie_user_rst) begin
      state_q       <= S_IDLE;
      busy_q        <= '0;
      owner_q       <= '0;
      rr_ptr_q      <= 1'b0;
      grant_q       <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      tag_q         <= '0;
      outstanding_q <= '0;
      tag_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      owner_q       <= owner_d;
      outstanding_q <= outstanding_d;
      if (cpl_stray) tag_err_q <= 1'b1;
      if (alloc) begin
        grant_q <= grant_d;
        tag_q   <= free_idx;
        addr_q  <= grant_d ? bus.req1_addr[C_PCIE_ADDR_WIDTH-1:2]
                           : bus.req0_addr[C_PCIE_ADDR_WIDTH-1:2];
        len_q   <= grant_d ? bus.req1_len : bus.req0_len;
      end
      if (state_q == S_ACK) rr_ptr_q <= ~grant_q;
    end
  end

  assign bus.tx_mrd_req        = (state_q == S_REQ);
  assign bus.tx_mrd_addr       = addr_q;
  assign bus.tx_mrd_len        = len_q;
  assign bus.tx_mrd_tag        = {{(8 - C_TAG_WIDTH){1'b0}}, tag_q};
  assign bus.req0_ready        = (state_q == S_ACK) && !grant_q;
  assign bus.req1_ready        = (state_q == S_ACK) && grant_q;
  assign bus.cpld_owner        = owner_q[cpl_idx];
  assign bus.tag_outstanding   = outstanding_q;
  assign bus.pcie_cpld_tag_err = tag_err_q;
endmodule

// File: tb/tb_pcie_rx_tag_sched.sv
// Directed bench for pcie_rx_tag_sched: arbitration, tag allocation/release,
// owner steering, stray-tag error and mid-transaction reset.
module tb_pcie_rx_tag_sched;
  logic pcie_user_clk = 1'b0;
  logic pcie_user_rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pcie_rx_tag_sched_if #(.C_TAG_WIDTH(3), .C_PCIE_ADDR_WIDTH(36)) bus ();

  pcie_rx_tag_sched #(.C_TAG_WIDTH(3), .C_PCIE_ADDR_WIDTH(36)) dut (
    .pcie_user_clk(pcie_user_clk),
    .pcie_user_rst(pcie_user_rst),
    .bus(bus)
  );

  always #5 pcie_user_clk = ~pcie_user_clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge pcie_user_clk);
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_len = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_len = '0;
    bus.tx_mrd_ack = 1'b0; bus.cpld_fifo_tag = '0;
    bus.cpld_fifo_wr_en = 1'b0; bus.cpld_fifo_tag_last = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    pcie_user_rst = 1'b1;
    tick(); tick();
    pcie_user_rst = 1'b0;
    tick();
  endtask

  task automatic wait_tx(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (bus.tx_mrd_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Runs one request from a single requester to completion of its ready pulse.
  task automatic issue(input int r, input logic [35:0] a, input logic [9:0] l,
                       input int ack_delay, output bit ok, output logic [7:0] tag,
                       output logic [33:0] addr, output logic [9:0] len,
                       output logic rdy0, output logic rdy1, output bit held);
    if (r == 0) begin bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_len = l; end
    else        begin bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_len = l; end
    wait_tx(ok);
    tag = bus.tx_mrd_tag; addr = bus.tx_mrd_addr; len = bus.tx_mrd_len;
    held = ok;
    rdy0 = 1'b0; rdy1 = 1'b0;
    if (ok) begin
      repeat (ack_delay) begin
        tick();
        held = held && (bus.tx_mrd_req === 1'b1) && (bus.tx_mrd_tag === tag);
      end
      bus.tx_mrd_ack = 1'b1;
      tick();
      bus.tx_mrd_ack = 1'b0;
      rdy0 = bus.req0_ready; rdy1 = bus.req1_ready;
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.tx_mrd_req, bus.req0_ready, bus.req1_ready, bus.pcie_cpld_tag_err} !== 4'b0 ||
        bus.tag_outstanding !== 4'd0 || bus.tx_mrd_tag !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_state got req=%b out=%0d tag=%0d err=%b required all zero",
               bus.tx_mrd_req, bus.tag_outstanding, bus.tx_mrd_tag, bus.pcie_cpld_tag_err);
    end
  endtask

  task automatic test_single_request();
    bit ok, held; logic [7:0] tag; logic [33:0] addr; logic [9:0] len; logic r0, r1;
    apply_reset();
    issue(0, 36'h1000, 10'd32, 2, ok, tag, addr, len, r0, r1, held);
    checks++;
    if (!ok) begin errors++; $display("[TB] FAIL single_timeout got no tx_mrd_req required one"); end
    checks++;
    if (addr !== 34'h400 || len !== 10'd32 || tag !== 8'd0) begin
      errors++;
      $display("[TB] FAIL single_fields got addr=%h len=%0d tag=%0d required 400/32/0", addr, len, tag);
    end
    checks++;
    if (!held) begin errors++; $display("[TB] FAIL single_hold got unstable request required held until ack"); end
    checks++;
    if (r0 !== 1'b1 || r1 !== 1'b0) begin
      errors++; $display("[TB] FAIL single_ready got r0=%b r1=%b required 1/0", r0, r1);
    end
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.tag_outstanding !== 4'd1) begin
      errors++;
      $display("[TB] FAIL single_after got ready=%b out=%0d required 0/1", bus.req0_ready, bus.tag_outstanding);
    end
  endtask

  task automatic test_round_robin();
    bit ok; int g;
    apply_reset();
    bus.req0_valid = 1'b1; bus.req0_addr = 36'h2000; bus.req0_len = 10'd4;
    bus.req1_valid = 1'b1; bus.req1_addr = 36'h3000; bus.req1_len = 10'd8;
    for (int i = 0; i < 4; i++) begin
      g = i % 2;
      wait_tx(ok);
      checks++;
      if (!ok || bus.tx_mrd_addr !== (g ? 34'hC00 : 34'h800) || bus.tx_mrd_tag !== 8'(i) ||
          bus.tx_mrd_len !== (g ? 10'd8 : 10'd4)) begin
        errors++;
        $display("[TB] FAIL rr_grant%0d got ok=%b addr=%h tag=%0d required addr=%h tag=%0d",
                 i, ok, bus.tx_mrd_addr, bus.tx_mrd_tag, (g ? 34'hC00 : 34'h800), i);
      end
      bus.tx_mrd_ack = 1'b1;
      tick();
      bus.tx_mrd_ack = 1'b0;
      checks++;
      if (bus.req0_ready !== (g == 0) || bus.req1_ready !== (g == 1)) begin
        errors++;
        $display("[TB] FAIL rr_ready%0d got r0=%b r1=%b required grant %0d", i, bus.req0_ready, bus.req1_ready, g);
      end
      if (i == 3) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
    end
    tick();
    checks++;
    if (bus.tag_outstanding !== 4'd4) begin
      errors++; $display("[TB] FAIL rr_outstanding got %0d required 4", bus.tag_outstanding);
    end
  endtask

  task automatic test_pool_exhaustion();
    bit ok, held, stalled; logic [7:0] tag; logic [33:0] addr; logic [9:0] len; logic r0, r1;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      issue(i % 2, 36'h100 * i, 10'd1, 0, ok, tag, addr, len, r0, r1, held);
      checks++;
      if (!ok || tag !== 8'(i)) begin
        errors++; $display("[TB] FAIL pool_tag%0d got ok=%b tag=%0d required %0d", i, ok, tag, i);
      end
    end
    checks++;
    if (bus.tag_outstanding !== 4'd8) begin
      errors++; $display("[TB] FAIL pool_full got %0d required 8", bus.tag_outstanding);
    end
    bus.req0_valid = 1'b1; bus.req0_addr = 36'h9000; bus.req0_len = 10'd2;
    stalled = 1'b1;
    repeat (5) begin tick(); stalled = stalled && (bus.tx_mrd_req === 1'b0); end
    checks++;
    if (!stalled) begin errors++; $display("[TB] FAIL pool_stall got request issued required stall"); end
    bus.cpld_fifo_tag = 8'd5; bus.cpld_fifo_wr_en = 1'b1; bus.cpld_fifo_tag_last = 1'b1;
    tick();
    bus.cpld_fifo_wr_en = 1'b0; bus.cpld_fifo_tag_last = 1'b0;
    checks++;
    if (bus.tag_outstanding !== 4'd7) begin
      errors++; $display("[TB] FAIL pool_release got %0d required 7", bus.tag_outstanding);
    end
    wait_tx(ok);
    checks++;
    if (!ok || bus.tx_mrd_tag !== 8'd5 || bus.tx_mrd_addr !== 34'h2400) begin
      errors++; $display("[TB] FAIL pool_reuse got ok=%b tag=%0d required tag 5", ok, bus.tx_mrd_tag);
    end
    bus.tx_mrd_ack = 1'b1; tick(); bus.tx_mrd_ack = 1'b0;
    bus.req0_valid = 1'b0; tick();
  endtask

  task automatic test_owner_release();
    bit ok, held; logic [7:0] tag; logic [33:0] addr; logic [9:0] len; logic r0, r1;
    apply_reset();
    issue(0, 36'h10, 10'd1, 0, ok, tag, addr, len, r0, r1, held);
    issue(0, 36'h20, 10'd1, 0, ok, tag, addr, len, r0, r1, held);
    issue(1, 36'h30, 10'd1, 0, ok, tag, addr, len, r0, r1, held);
    checks++;
    if (!ok || tag !== 8'd2 || r1 !== 1'b1) begin
      errors++; $display("[TB] FAIL owner_setup got ok=%b tag=%0d r1=%b required tag 2 r1=1", ok, tag, r1);
    end
    bus.cpld_fifo_tag = 8'd2; bus.cpld_fifo_wr_en = 1'b1;
    #1;
    checks++;
    if (bus.cpld_owner !== 1'b1) begin
      errors++; $display("[TB] FAIL owner_tag2 got %b required 1", bus.cpld_owner);
    end
    tick();
    bus.cpld_fifo_wr_en = 1'b0;
    checks++;
    if (bus.tag_outstanding !== 4'd3 || bus.pcie_cpld_tag_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL owner_nolast got out=%0d err=%b required 3/0", bus.tag_outstanding, bus.pcie_cpld_tag_err);
    end
    bus.cpld_fifo_tag = 8'd0;
    #1;
    checks++;
    if (bus.cpld_owner !== 1'b0) begin
      errors++; $display("[TB] FAIL owner_tag0 got %b required 0", bus.cpld_owner);
    end
    bus.cpld_fifo_tag = 8'd2; bus.cpld_fifo_wr_en = 1'b1; bus.cpld_fifo_tag_last = 1'b1;
    tick();
    bus.cpld_fifo_wr_en = 1'b0; bus.cpld_fifo_tag_last = 1'b0;
    checks++;
    if (bus.tag_outstanding !== 4'd2 || bus.pcie_cpld_tag_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL owner_last got out=%0d err=%b required 2/0", bus.tag_outstanding, bus.pcie_cpld_tag_err);
    end
    issue(0, 36'h40, 10'd1, 0, ok, tag, addr, len, r0, r1, held);
    checks++;
    if (!ok || tag !== 8'd2) begin
      errors++; $display("[TB] FAIL owner_realloc got tag=%0d required 2", tag);
    end
  endtask

  task automatic test_tag_error();
    bit sticky;
    bus.cpld_fifo_tag = 8'h09; bus.cpld_fifo_wr_en = 1'b1; bus.cpld_fifo_tag_last = 1'b1;
    tick();
    bus.cpld_fifo_wr_en = 1'b0; bus.cpld_fifo_tag_last = 1'b0;
    checks++;
    if (bus.pcie_cpld_tag_err !== 1'b1 || bus.tag_outstanding !== 4'd3) begin
      errors++;
      $display("[TB] FAIL err_outofpool got err=%b out=%0d required 1/3", bus.pcie_cpld_tag_err, bus.tag_outstanding);
    end
    sticky = 1'b1;
    repeat (3) begin tick(); sticky = sticky && (bus.pcie_cpld_tag_err === 1'b1); end
    checks++;
    if (!sticky) begin errors++; $display("[TB] FAIL err_sticky got cleared required held"); end
    apply_reset();
    checks++;
    if (bus.pcie_cpld_tag_err !== 1'b0) begin
      errors++; $display("[TB] FAIL err_reset got %b required 0", bus.pcie_cpld_tag_err);
    end
    bus.cpld_fifo_tag = 8'd3; bus.cpld_fifo_wr_en = 1'b1; bus.cpld_fifo_tag_last = 1'b1;
    tick();
    bus.cpld_fifo_wr_en = 1'b0; bus.cpld_fifo_tag_last = 1'b0;
    checks++;
    if (bus.pcie_cpld_tag_err !== 1'b1 || bus.tag_outstanding !== 4'd0) begin
      errors++;
      $display("[TB] FAIL err_freetag got err=%b out=%0d required 1/0", bus.pcie_cpld_tag_err, bus.tag_outstanding);
    end
  endtask

  task automatic test_reset_mid_request();
    bit ok, held; logic [7:0] tag; logic [33:0] addr; logic [9:0] len; logic r0, r1;
    apply_reset();
    for (int i = 0; i < 3; i++) issue(0, 36'h80, 10'd1, 0, ok, tag, addr, len, r0, r1, held);
    bus.req1_valid = 1'b1; bus.req1_addr = 36'h5000; bus.req1_len = 10'd16;
    wait_tx(ok);
    checks++;
    if (!ok || bus.tx_mrd_tag !== 8'd3 || bus.tag_outstanding !== 4'd4) begin
      errors++;
      $display("[TB] FAIL midrst_setup got ok=%b tag=%0d out=%0d required tag 3 out 4",
               ok, bus.tx_mrd_tag, bus.tag_outstanding);
    end
    bus.req1_valid = 1'b0;
    pcie_user_rst = 1'b1;
    tick();
    pcie_user_rst = 1'b0;
    checks++;
    if (bus.tx_mrd_req !== 1'b0 || bus.tag_outstanding !== 4'd0 ||
        bus.tx_mrd_tag !== 8'd0 || bus.tx_mrd_addr !== 34'd0 || bus.tx_mrd_len !== 10'd0) begin
      errors++;
      $display("[TB] FAIL midrst_clear got req=%b out=%0d tag=%0d addr=%h required all zero",
               bus.tx_mrd_req, bus.tag_outstanding, bus.tx_mrd_tag, bus.tx_mrd_addr);
    end
    bus.tx_mrd_ack = 1'b1;
    tick();
    bus.tx_mrd_ack = 1'b0;
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.tx_mrd_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_lateack got r0=%b r1=%b req=%b required 0/0/0",
               bus.req0_ready, bus.req1_ready, bus.tx_mrd_req);
    end
    tick();
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_noready got r0=%b r1=%b required 0/0", bus.req0_ready, bus.req1_ready);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_request();
    test_round_robin();
    test_pool_exhaustion();
    test_owner_release();
    test_tag_error();
    test_reset_mid_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
